// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter run controller.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/count_core.sv
// Count register for the sequencer; clear has priority over increment.
module count_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_zero,
    input  logic             step,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_zero) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run controller: FSM, prescaler and captured config driving a count_core datapath.
module counter_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  abort,
    input  logic                  mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  busy,
    output logic                  done
);

    import counter_ctrl_pkg::*;

    seq_state_t            state_q, state_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0]      limit_sh_q;
    logic [PRESCALE_W-1:0] prescale_sh_q;
    logic                  mode_sh_q;
    logic                  tick_q, busy_q, done_q;
    logic [WIDTH-1:0]      count_w;

    logic load_cfg, step_evt, terminal, core_zero, core_step;

    // halt outranks start, so a simultaneous halt blocks a load
    assign load_cfg  = !abort && !halt && start && (state_q == IDLE || state_q == DONE)
                       && (limit != '0);
    assign step_evt  = (state_q == RUN) && (presc_q == prescale_sh_q);
    assign terminal  = step_evt && (count_w == limit_sh_q);
    assign core_zero = abort || load_cfg || (terminal && mode_sh_q == MODE_PERIODIC);
    assign core_step = step_evt && !terminal;

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .clear_n  (clear_n),
        .load_zero(core_zero),
        .step     (core_step),
        .count    (count_w)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (load_cfg) state_d = RUN;
                RUN: begin
                    // terminal one-shot step completes even under halt
                    if (terminal && mode_sh_q == MODE_ONESHOT) state_d = DONE;
                    else if (halt)                            state_d = PAUSE;
                end
                PAUSE: if (!halt && start) state_d = RUN;
                DONE:  if (load_cfg) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (abort || load_cfg) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            presc_d = step_evt ? '0 : presc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            limit_sh_q    <= '0;
            prescale_sh_q <= '0;
            mode_sh_q     <= 1'b0;
            tick_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            if (load_cfg) begin
                limit_sh_q    <= limit;
                prescale_sh_q <= prescale;
                mode_sh_q     <= mode;
            end
            tick_q <= terminal && !abort;
            busy_q <= (state_d == RUN) || (state_d == PAUSE);
            done_q <= (state_d == DONE);
        end
    end

    assign count = count_w;
    assign tick  = tick_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with hand-computed expectations.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       start, halt, abort, mode;
    logic [3:0] limit;
    logic [3:0] prescale;
    logic [3:0] count;
    logic       tick, busy, done;

    int passed = 0;
    int total  = 0;

    counter_sequencer #(
        .WIDTH(4),
        .PRESCALE_W(4)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (start),
        .halt    (halt),
        .abort   (abort),
        .mode    (mode),
        .limit   (limit),
        .prescale(prescale),
        .count   (count),
        .tick    (tick),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] l, input logic [3:0] p, input logic m);
        limit = l; prescale = p; mode = m; start = 1'b1;
        clk_step();
        start = 1'b0;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        clk_step();
        abort = 1'b0;
        total++;
        if ({count, tick, busy, done} !== {4'd0, 1'b0, 1'b0, 1'b0})
            $display("FAIL go_idle: got c=%0d t=%b b=%b d=%b want 0 0 0 0",
                     count, tick, busy, done);
        else passed++;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; start = 0; halt = 0; abort = 0; mode = 0; limit = 0; prescale = 0;
        repeat (2) clk_step();
        total++;
        if ({count, tick, busy, done} !== 7'd0)
            $display("FAIL reset: got c=%0d t=%b b=%b d=%b want all 0", count, tick, busy, done);
        else passed++;
        @(negedge clk);
        clear_n = 1'b1;
        clk_step();
    endtask

    task automatic test_oneshot();
        load(4'd5, 4'd0, 1'b0);
        total++;
        if ({count, tick, busy, done} !== {4'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL oneshot_entry: got c=%0d t=%b b=%b d=%b want 0 0 1 0",
                     count, tick, busy, done);
        else passed++;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] ec;
            logic       et, eb, ed;
            clk_step();
            ec = (k < 5) ? 4'(k) : 4'd5;
            et = (k == 6);
            eb = (k < 6);
            ed = (k >= 6);
            total++;
            if ({count, tick, busy, done} !== {ec, et, eb, ed})
                $display("FAIL oneshot k=%0d: got c=%0d t=%b b=%b d=%b want c=%0d t=%b b=%b d=%b",
                         k, count, tick, busy, done, ec, et, eb, ed);
            else passed++;
        end
    endtask

    task automatic test_periodic();
        load(4'd3, 4'd1, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            logic [3:0] ec;
            logic       et;
            clk_step();
            ec = 4'((k % 8) / 2);
            et = (k % 8 == 0);
            total++;
            if ({count, tick, busy, done} !== {ec, et, 1'b1, 1'b0})
                $display("FAIL periodic k=%0d: got c=%0d t=%b b=%b d=%b want c=%0d t=%b b=1 d=0",
                         k, count, tick, busy, done, ec, et);
            else passed++;
        end
        go_idle();
    endtask

    task automatic test_wrap();
        load(4'd15, 4'd0, 1'b1);
        for (int k = 1; k <= 48; k++) begin
            logic [3:0] ec;
            logic       et;
            clk_step();
            ec = 4'(k % 16);
            et = (k % 16 == 0);
            total++;
            if ({count, tick, busy, done} !== {ec, et, 1'b1, 1'b0})
                $display("FAIL wrap k=%0d: got c=%0d t=%b b=%b d=%b want c=%0d t=%b b=1 d=0",
                         k, count, tick, busy, done, ec, et);
            else passed++;
        end
        go_idle();
    endtask

    task automatic test_pause();
        int first_tick = -1;
        load(4'd9, 4'd2, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            halt  = (k >= 7 && k <= 11);
            start = (k == 12);
            clk_step();
            if (tick && first_tick < 0) first_tick = k;
            if (k >= 7 && k <= 12) begin
                total++;
                if ({count, busy} !== {4'd2, 1'b1})
                    $display("FAIL pause_hold k=%0d: got c=%0d b=%b want c=2 b=1", k, count, busy);
                else passed++;
            end
        end
        halt = 0; start = 0;
        total++;
        if (first_tick != 35)
            $display("FAIL pause_tick: got tick at cycle %0d want 35", first_tick);
        else passed++;
        total++;
        if ({count, busy, done} !== {4'd9, 1'b0, 1'b1})
            $display("FAIL pause_done: got c=%0d b=%b d=%b want 9 0 1", count, busy, done);
        else passed++;
        go_idle();
    endtask

    task automatic test_abort();
        load(4'd9, 4'd0, 1'b0);
        repeat (4) clk_step();
        total++;
        if (count !== 4'd4) $display("FAIL abort_pre: got c=%0d want 4", count);
        else passed++;
        go_idle();
        // abort on the would-be terminal edge must swallow the tick
        load(4'd3, 4'd0, 1'b0);
        repeat (3) clk_step();
        go_idle();
        clk_step();
        total++;
        if ({tick, done} !== 2'b00) $display("FAIL abort_tick: got t=%b d=%b want 0 0", tick, done);
        else passed++;
        load(4'd9, 4'd0, 1'b1);
        repeat (3) clk_step();
        #2 clear_n = 1'b0;
        #1;
        total++;
        if ({count, tick, busy, done} !== 7'd0)
            $display("FAIL async_clear: got c=%0d t=%b b=%b d=%b want all 0",
                     count, tick, busy, done);
        else passed++;
        @(negedge clk);
        clear_n = 1'b1;
        clk_step();
    endtask

    task automatic test_config();
        int first_tick = -1;
        load(4'd0, 4'd0, 1'b0);
        total++;
        if ({count, busy, done} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL limit_zero: got c=%0d b=%b d=%b want 0 0 0", count, busy, done);
        else passed++;
        load(4'd5, 4'd0, 1'b0);
        limit = 4'd2;
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            if (tick && first_tick < 0) first_tick = k;
        end
        total++;
        if (first_tick != 6 || count !== 4'd5)
            $display("FAIL limit_change: got tick at %0d c=%0d want 6 c=5", first_tick, count);
        else passed++;
        load(4'd2, 4'd0, 1'b0);
        total++;
        if ({count, busy, done} !== {4'd0, 1'b1, 1'b0})
            $display("FAIL done_restart: got c=%0d b=%b d=%b want 0 1 0", count, busy, done);
        else passed++;
        first_tick = -1;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            if (tick && first_tick < 0) first_tick = k;
        end
        total++;
        if (first_tick != 3) $display("FAIL restart_tick: got tick at %0d want 3", first_tick);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_pause();
        test_abort();
        test_config();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Programmable run controller that sequences a WIDTH-bit up-counter datapath.
- Provides start/halt/abort control, a prescaler, one-shot or periodic modes, and a registered terminal-count tick.
- Sits between control logic and the counter so timing events such as strobes and timeouts come from one configured source, not free-running counters.

Parameters:
WIDTH, 4, width of count and limit
PRESCALE_W, 4, width of prescale and internal prescaler

Ports:
clk  in  1  system clock; all state changes on rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  level-sampled; in IDLE/DONE loads config and runs; in PAUSE resumes
halt  in  1  freezes a running sequence (RUN->PAUSE)
abort  in  1  returns to IDLE from any state, count cleared
mode  in  1  0 = one-shot, 1 = periodic; captured on load
limit  in  WIDTH  terminal count value; captured on load
prescale  in  PRESCALE_W  clocks per step minus 1; captured on load
count  out  WIDTH  current count value
tick  out  1  one-cycle pulse on terminal step
busy  out  1  high in RUN or PAUSE
done  out  1  high in DONE (one-shot finished)

Behaviour:
- One clock; reset is asynchronous and active-low (clear_n).
- All outputs are registered.
- Reset (clear_n=0, no clock required):
  - state=IDLE; count=0, tick=0, busy=0, done=0.
  - Prescaler=0; shadow regs = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority each edge: abort > halt > start.
- IDLE:
  - start with limit!=0: capture limit/prescale/mode into shadow regs, count=0, prescaler=0, go RUN.
  - start with limit==0: ignored, stay IDLE.
- RUN:
  - Prescaler increments each cycle. When prescaler==shadow prescale, a step occurs and the prescaler returns to 0.
  - Non-terminal step (count!=limit): count+1.
  - Terminal step (count==limit): tick=1 for that cycle.
    - Periodic: count=0, stay RUN.
    - One-shot: count holds limit, go DONE.
  - Timing: first tick comes (limit+1)*(prescale+1) cycles after RUN entry. Periodic ticks repeat with that same period.
  - start while in RUN is ignored.
  - Input changes on limit/prescale/mode have no effect until the next load.
- halt in RUN: go PAUSE; count and prescaler frozen.
  - If halt coincides with a terminal step, the step completes first (tick fires, count updates).
  - One-shot terminal step + halt: DONE wins over PAUSE.
- PAUSE:
  - start resumes RUN from the frozen count and prescaler; no reload, no tick on resume.
  - halt held: stay PAUSE.
- DONE:
  - done=1, busy=0, count holds limit.
  - start reloads config and enters RUN (count=0) on the same edge; done drops.
- abort in any state: IDLE next edge; count=0, tick=0, done=0, busy=0. A tick that would have fired on the same edge is suppressed.
- Arithmetic:
  - Equality compares only; count never exceeds limit, so there is no overflow.
  - limit=2^WIDTH-1 is legal and wraps to 0 in periodic mode.
  - prescale=0 means one step per clock.
- tick is never high for two consecutive cycles unless limit=0 and prescale=0. That case is unreachable because limit=0 is rejected.

Decomposition:
- Package counter_ctrl_pkg:
  - State enum typedef seq_state_t {IDLE, RUN, PAUSE, DONE}.
  - Mode constants MODE_ONESHOT=0, MODE_PERIODIC=1.
- Sub-module count_core (WIDTH):
  - Ports: clk, clear_n, load_zero, step, count.
  - Holds the count register, increment and wrap logic.
- counter_sequencer holds:
  - FSM, prescaler, shadow config regs.
  - Terminal detect, tick/busy/done registers.

Test Plan:
1. WIDTH=4, limit=5, prescale=0, mode=0, start pulse:
   - count goes 0,1,2,3,4,5 on successive cycles.
   - tick high exactly 6 cycles after RUN entry.
   - Then done=1, busy=0, count stays 5 for 10 further cycles.
2. limit=3, prescale=1, mode=1:
   - count sequence is 0,0,1,1,2,2,3,3,0,0...
   - tick pulses every 8 cycles for 4 periods, one cycle wide.
3. limit=15, prescale=0, mode=1:
   - count wraps 15->0 with tick on the wrap edge, every 16 cycles.
   - No X/overflow; busy stays 1.
4. Pause/resume: limit=9, prescale=2, halt when count=2 for 5 cycles, then start:
   - count and prescaler hold in PAUSE.
   - Terminal tick arrives exactly 5 cycles later than the unpaused case (30 -> 35 cycles after RUN entry).
5. Reset/abort:
   - abort at count=4 in RUN gives IDLE, count=0, busy=0 next edge, no tick.
   - Separately, clear_n driven low mid-run between clock edges zeroes all outputs immediately.
6. Config rules:
   - start with limit=0 stays IDLE.
   - Changing limit 5->2 during RUN is ignored (tick still at count 5).
   - start in DONE restarts with count=0 on the same edge.
